sprite_motion_ctrl: RTL and testbench
=====================================

# sprite_motion_ctrl

Frame-synchronous motion controller for the two-sprite engine. It holds position and signed velocity for sprite 0 and sprite 1. On each vertical-sync rising edge it runs a short update sequence that advances both positions, bounces them off the 256×192 logical screen edges and, when compiled in, detects box overlap between the sprites. It sits directly upstream of the sprite engine and drives that engine's sprite X/Y and horizontal-flip inputs. It is itself a register slave of the TinyQV peripheral bus.

## Interface
- `SCREEN_W`, default 256: logical screen width in sprite pixels.
- `SCREEN_H`, default 192: logical screen height.
- `SPR_SIZE`, default 12: sprite box edge length.

- `clk` in 1: single clock, 64 MHz project clock.
- `rst` in 1: reset, synchronous, active-high.
- `frame_tick` in 1: vsync level from the sprite engine timing generator.
- `wr_en` in 1: register write strobe.
- `wr_addr` in 3: write register index.
- `wr_data` in 16: write data.
- `rd_addr` in 3: read register index.
- `rd_data` out 16: combinational readback; unused indices read 0.
- `spr0_x`, `spr0_y`, `spr1_x`, `spr1_y` out 8: registered live positions.
- `spr0_hflip`, `spr1_hflip` out 1: registered; toggles on horizontal bounce.
- `update_done` out 1: one-cycle pulse at end of each update sequence.
- `collide_irq` out 1: collision sticky flag AND CTRL[1].

## Operation
- Register map:
  - 0 CTRL: [0] run, [1] collision-IRQ enable.
  - 1 STATUS: [0] collision sticky, write-1-to-clear; [1] busy, read-only.
  - 2 S0POS: {y[15:8], x[7:0]}.
  - 3 S0VEL: {dy[11:8], dx[3:0]}, 4-bit two's complement.
  - 4 S1POS and 5 S1VEL: same layout as S0POS and S0VEL.
  - 6 FRAMECNT: read-only.
  - Writes to S*POS/S*VEL are accepted at any time.
- Edge detect: `tick_q` register; `edge = frame_tick & ~tick_q & CTRL[0]`.
- FSM states IDLE → UPD0 → UPD1 → COLL → DONE → IDLE. Each non-IDLE state lasts one cycle. IDLE is left only on `edge`. Busy = state ≠ IDLE.
- Edges arriving while busy are ignored. `tick_q` still tracks `frame_tick`.
- UPDn, per axis:
  - `n = {1'b0,pos} + sext9(v)`, signed 10-bit. `max = SCREEN_W−SPR_SIZE` (244) for x, `SCREEN_H−SPR_SIZE` (180) for y.
  - If `n < 0`: pos ← 0, v ← −v.
  - If `n > max`: pos ← max, v ← −v.
  - Otherwise pos ← n[7:0].
  - Negation saturates: −(−8) = +7.
  - An x-axis bounce also toggles `sprN_hflip`.
- COLL: collision when `|x0−x1| < SPR_SIZE` and `|y0−y1| < SPR_SIZE` (9-bit unsigned differences). Sets the sticky bit. A W1C in the same cycle loses; the flag stays set.
- DONE: `update_done`=1 and FRAMECNT += 1, wrapping 0xFFFF→0.
- A CPU write to S*POS/S*VEL in the same cycle the FSM updates that sprite wins; the FSM result is discarded for that register.
- Clearing CTRL[0] mid-sequence does not abort; the sequence completes.
- `rst` mid-sequence: FSM to IDLE in the next cycle; everything takes reset values.

## Timing
- Reset values:
  - All positions, velocities, hflips, CTRL, STATUS, FRAMECNT and `tick_q`: 0.
  - FSM: IDLE.
  - `update_done`, `collide_irq`: 0.
- Let E be the clock edge where `edge`=1.
- Sprite 0 outputs change at E+1 and sprite 1 outputs change at E+2.
- Collision flag sets at E+3.
- `update_done` is high during [E+3, E+4) and FRAMECNT increments at E+4.
- `collide_irq` follows the sticky flag combinationally via CTRL[1], so it rises at E+3.
- The whole sequence finishes in under 5 cycles, well inside the 6-line vsync pulse, so no tearing occurs.

## Configuration
- `SPRITE_MOTION_COLLIDE_EN` defined:
  - COLL state and overlap logic are present.
  - `update_done` is high during [E+3, E+4).
- Undefined:
  - FSM goes UPD1 → DONE; `update_done` is high during [E+2, E+3) and FRAMECNT increments at E+3.
  - STATUS[0] reads 0 and `collide_irq` is tied 0. CTRL[1] is writable but has no effect.

## Test plan
- Reset: assert `rst` 2 cycles → all outputs 0, `rd_data` at index 6 = 0, FSM IDLE.
- Basic motion: S0POS=0x1010, S0VEL=0x0102 (dx=+2, dy=+1), run=1, one vsync rise → `spr0_x`=0x12, `spr0_y`=0x11 at E+1; FRAMECNT=1.
- Right bounce: x=243, dx=+3 → x=244, dx reads 0xD (−3), `spr0_hflip`=1. Next frame → x=241.
- Saturating negate: x=2, dx=−8 → x=0, dx=+7. Also check run=0 plus vsync → no change and `update_done` stays 0.
- Collision: S0POS=(50,50), S1POS=(61,55), velocities 0, CTRL=0b11, vsync → `collide_irq`=1 at E+3. W1C STATUS → 0. Repeat with x1=62 → no collision.
- Write conflict: write S1POS=0x2020 on cycle E+1 (UPD1) while dx1=+1 → `spr1_x` reads 0x20, not 0x21. Without the macro, `update_done` is high during [E+2, E+3) and `collide_irq` stays 0.

Source files
------------

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: frame-synchronous position/velocity controller for two sprites.
// Each vsync rising edge advances both sprites and bounces them off the screen edges.
// Optional box-overlap collision detection is compiled in with SPRITE_MOTION_COLLIDE_EN.
module sprite_motion_ctrl #(
  parameter int unsigned SCREEN_W = 256,
  parameter int unsigned SCREEN_H = 192,
  parameter int unsigned SPR_SIZE = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [7:0]  spr0_x,
  output logic [7:0]  spr0_y,
  output logic [7:0]  spr1_x,
  output logic [7:0]  spr1_y,
  output logic        spr0_hflip,
  output logic        spr1_hflip,
  output logic        update_done,
  output logic        collide_irq
);

  localparam logic [7:0] X_MAX = 8'(SCREEN_W - SPR_SIZE);
  localparam logic [7:0] Y_MAX = 8'(SCREEN_H - SPR_SIZE);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_S0POS  = 3'd2;
  localparam logic [2:0] A_S0VEL  = 3'd3;
  localparam logic [2:0] A_S1POS  = 3'd4;
  localparam logic [2:0] A_S1VEL  = 3'd5;
  localparam logic [2:0] A_FRAME  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UPD0 = 3'd1,
    ST_UPD1 = 3'd2,
    ST_COLL = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] pos;
    logic [3:0] vel;
    logic       bounce;
  } axis_t;

  // Two's complement negate of a 4-bit velocity; -8 saturates to +7.
  function automatic logic [3:0] neg_sat(input logic [3:0] v);
    return (v == 4'b1000) ? 4'b0111 : (~v + 4'd1);
  endfunction

  // One axis step: advance by velocity, clamp and reflect at 0 and lim.
  function automatic axis_t axis_step(input logic [7:0] pos,
                                      input logic [3:0] vel,
                                      input logic [7:0] lim);
    logic signed [9:0] n;
    axis_t r;
    n = $signed({2'b00, pos}) + $signed({{6{vel[3]}}, vel});
    r.pos    = n[7:0];
    r.vel    = vel;
    r.bounce = 1'b0;
    if (n[9]) begin
      r.pos    = 8'd0;
      r.vel    = neg_sat(vel);
      r.bounce = 1'b1;
    end else if (n > $signed({2'b00, lim})) begin
      r.pos    = lim;
      r.vel    = neg_sat(vel);
      r.bounce = 1'b1;
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic        tick_q;
  logic        vsync_rise;
  logic        ctrl_run, ctrl_irq_en;
  logic        coll_sticky;
  logic        coll_set;
  logic [15:0] framecnt;
  logic [3:0]  vel0_x, vel0_y, vel1_x, vel1_y;
  logic [7:0]  cur_x, cur_y;
  logic [3:0]  cur_vx, cur_vy;
  axis_t       ax, ay;
  logic        busy;
  logic        clr_w1c;

  assign vsync_rise = frame_tick & ~tick_q & ctrl_run;
  assign busy       = (state_q != ST_IDLE);
  assign clr_w1c    = wr_en && (wr_addr == A_STATUS) && wr_data[0];

  // Next-state logic for the update sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (vsync_rise) state_d = ST_UPD0;
      ST_UPD0: state_d = ST_UPD1;
`ifdef SPRITE_MOTION_COLLIDE_EN
      ST_UPD1: state_d = ST_COLL;
`else
      ST_UPD1: state_d = ST_DONE;
`endif
      ST_COLL: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, vsync history and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= 1'b0;
      update_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= frame_tick;
      update_done <= (state_d == ST_DONE);
    end
  end

  // Shared axis datapath; the sprite being updated is picked by the state.
  always_comb begin
    cur_x  = spr0_x;
    cur_y  = spr0_y;
    cur_vx = vel0_x;
    cur_vy = vel0_y;
    if (state_q == ST_UPD1) begin
      cur_x  = spr1_x;
      cur_y  = spr1_y;
      cur_vx = vel1_x;
      cur_vy = vel1_y;
    end
    ax = axis_step(cur_x, cur_vx, X_MAX);
    ay = axis_step(cur_y, cur_vy, Y_MAX);
  end

`ifdef SPRITE_MOTION_COLLIDE_EN
  logic [8:0] diff_x, diff_y;

  // Box overlap test on the freshly updated positions.
  always_comb begin
    diff_x = (spr0_x >= spr1_x) ? ({1'b0, spr0_x} - {1'b0, spr1_x})
                                : ({1'b0, spr1_x} - {1'b0, spr0_x});
    diff_y = (spr0_y >= spr1_y) ? ({1'b0, spr0_y} - {1'b0, spr1_y})
                                : ({1'b0, spr1_y} - {1'b0, spr0_y});
    coll_set = (state_q == ST_COLL) &&
               (diff_x < 9'(SPR_SIZE)) && (diff_y < 9'(SPR_SIZE));
  end

  assign collide_irq = coll_sticky & ctrl_irq_en;
`else
  assign coll_set    = 1'b0;
  assign collide_irq = 1'b0;
`endif

  // Sprite position/velocity/flip; a CPU write in the same cycle overrides the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      spr0_x     <= 8'd0;
      spr0_y     <= 8'd0;
      spr1_x     <= 8'd0;
      spr1_y     <= 8'd0;
      vel0_x     <= 4'd0;
      vel0_y     <= 4'd0;
      vel1_x     <= 4'd0;
      vel1_y     <= 4'd0;
      spr0_hflip <= 1'b0;
      spr1_hflip <= 1'b0;
    end else begin
      if (state_q == ST_UPD0) begin
        spr0_x <= ax.pos;
        spr0_y <= ay.pos;
        vel0_x <= ax.vel;
        vel0_y <= ay.vel;
        if (ax.bounce) spr0_hflip <= ~spr0_hflip;
      end
      if (state_q == ST_UPD1) begin
        spr1_x <= ax.pos;
        spr1_y <= ay.pos;
        vel1_x <= ax.vel;
        vel1_y <= ay.vel;
        if (ax.bounce) spr1_hflip <= ~spr1_hflip;
      end
      if (wr_en) begin
        case (wr_addr)
          A_S0POS: begin
            spr0_x <= wr_data[7:0];
            spr0_y <= wr_data[15:8];
          end
          A_S0VEL: begin
            vel0_x <= wr_data[3:0];
            vel0_y <= wr_data[11:8];
          end
          A_S1POS: begin
            spr1_x <= wr_data[7:0];
            spr1_y <= wr_data[15:8];
          end
          A_S1VEL: begin
            vel1_x <= wr_data[3:0];
            vel1_y <= wr_data[11:8];
          end
          default: ;
        endcase
      end
    end
  end

  // Control, sticky collision flag and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_run    <= 1'b0;
      ctrl_irq_en <= 1'b0;
      coll_sticky <= 1'b0;
      framecnt    <= 16'd0;
    end else begin
      if (wr_en && (wr_addr == A_CTRL)) begin
        ctrl_run    <= wr_data[0];
        ctrl_irq_en <= wr_data[1];
      end
      if (clr_w1c) coll_sticky <= 1'b0;
      if (coll_set) coll_sticky <= 1'b1;
      if (state_q == ST_DONE) framecnt <= framecnt + 16'd1;
    end
  end

  // Register readback.
  always_comb begin
    rd_data = 16'd0;
    case (rd_addr)
      A_CTRL:   rd_data = {14'd0, ctrl_irq_en, ctrl_run};
      A_STATUS: rd_data = {14'd0, busy, coll_sticky};
      A_S0POS:  rd_data = {spr0_y, spr0_x};
      A_S0VEL:  rd_data = {4'd0, vel0_y, 4'd0, vel0_x};
      A_S1POS:  rd_data = {spr1_y, spr1_x};
      A_S1VEL:  rd_data = {4'd0, vel1_y, 4'd0, vel1_x};
      A_FRAME:  rd_data = framecnt;
      default:  rd_data = 16'd0;
    endcase
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed self-checking bench for sprite_motion_ctrl.
module tb_sprite_motion_ctrl;

`ifdef SPRITE_MOTION_COLLIDE_EN
  localparam int   DONE_AT  = 3;
  localparam logic COLL_EXP = 1'b1;
`else
  localparam int   DONE_AT  = 2;
  localparam logic COLL_EXP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  spr0_x, spr0_y, spr1_x, spr1_y;
  logic        spr0_hflip, spr1_hflip;
  logic        update_done, collide_irq;

  int errors = 0;
  int checks = 0;
  logic [15:0] rv;

  sprite_motion_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .spr0_x     (spr0_x),
    .spr0_y     (spr0_y),
    .spr1_x     (spr1_x),
    .spr1_y     (spr1_y),
    .spr0_hflip (spr0_hflip),
    .spr1_hflip (spr1_hflip),
    .update_done(update_done),
    .collide_irq(collide_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  // One vsync pulse; update_done must pulse exactly at E+DONE_AT when running.
  task automatic frame(input string tag, input bit expect_run);
    frame_tick = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk(tag, 16'(update_done), 16'(expect_run && (k == DONE_AT)));
    end
    frame_tick = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; wr_en = 1'b0;
    wr_addr = 3'd0; wr_data = 16'd0; rd_addr = 3'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_pos", {spr0_x, spr0_y}, 16'h0000);
    chk("rst_pos1", {spr1_x, spr1_y}, 16'h0000);
    chk("rst_flags", {12'd0, spr0_hflip, spr1_hflip, update_done, collide_irq}, 16'h0000);
    rd(3'd6, rv); chk("rst_framecnt", rv, 16'h0000);
    rd(3'd1, rv); chk("rst_status", rv, 16'h0000);
    rd(3'd0, rv); chk("rst_ctrl", rv, 16'h0000);

    // Basic motion with cycle-accurate checks
    wr(3'd2, 16'h1010);
    wr(3'd3, 16'h0102);
    wr(3'd0, 16'h0001);
    frame_tick = 1'b1;
    tick();
    chk("basic_e0_x", 16'(spr0_x), 16'h0010);
    rd(3'd1, rv); chk("basic_busy", rv, 16'h0002);
    tick();
    chk("basic_e1_x", 16'(spr0_x), 16'h0012);
    chk("basic_e1_y", 16'(spr0_y), 16'h0011);
    tick();
    chk("basic_done_e2", 16'(update_done), 16'(DONE_AT == 2));
    tick();
    chk("basic_done_e3", 16'(update_done), 16'(DONE_AT == 3));
    tick();
    frame_tick = 1'b0;
    tick();
    rd(3'd6, rv); chk("basic_framecnt", rv, 16'h0001);
    chk("basic_spr1", {spr1_y, spr1_x}, 16'h0000);

    // Right-edge bounce then move back
    wr(3'd2, 16'h10F3);
    wr(3'd3, 16'h0003);
    frame("bounce_done", 1'b1);
    chk("bounce_x", 16'(spr0_x), 16'h00F4);
    rd(3'd3, rv); chk("bounce_vel", rv, 16'h000D);
    chk("bounce_hflip", 16'(spr0_hflip), 16'h0001);
    frame("bounce2_done", 1'b1);
    chk("bounce2_x", 16'(spr0_x), 16'h00F1);
    chk("bounce2_y", 16'(spr0_y), 16'h0010);

    // Left-edge bounce with saturating negate
    wr(3'd2, 16'h1002);
    wr(3'd3, 16'h0008);
    frame("sat_done", 1'b1);
    chk("sat_x", 16'(spr0_x), 16'h0000);
    rd(3'd3, rv); chk("sat_vel", rv, 16'h0007);
    chk("sat_hflip", 16'(spr0_hflip), 16'h0000);

    // run=0: vsync ignored
    wr(3'd0, 16'h0000);
    frame("stop_done", 1'b0);
    chk("stop_x", 16'(spr0_x), 16'h0000);
    rd(3'd6, rv); chk("stop_framecnt", rv, 16'h0004);

    // Collision: |dx|=11, |dy|=5
    wr(3'd2, 16'h3232);
    wr(3'd3, 16'h0000);
    wr(3'd4, 16'h373D);
    wr(3'd5, 16'h0000);
    wr(3'd0, 16'h0003);
    frame("coll_done", 1'b1);
    chk("coll_irq", 16'(collide_irq), 16'(COLL_EXP));
    rd(3'd1, rv); chk("coll_status", rv, 16'(COLL_EXP));
    wr(3'd1, 16'h0001);
    chk("coll_w1c_irq", 16'(collide_irq), 16'h0000);
    rd(3'd1, rv); chk("coll_w1c_status", rv, 16'h0000);

    // No collision at |dx| = SPR_SIZE
    wr(3'd4, 16'h373E);
    frame("nocoll_done", 1'b1);
    chk("nocoll_irq", 16'(collide_irq), 16'h0000);
    rd(3'd1, rv); chk("nocoll_status", rv, 16'h0000);

    // CPU write during UPD1 beats the FSM result
    wr(3'd5, 16'h0001);
    frame_tick = 1'b1;
    tick();
    tick();
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h2020;
    tick();
    wr_en = 1'b0;
    chk("conflict_pos", {spr1_y, spr1_x}, 16'h2020);
    chk("conflict_done_e2", 16'(update_done), 16'(DONE_AT == 2));
    tick();
    chk("conflict_done_e3", 16'(update_done), 16'(DONE_AT == 3));
    chk("conflict_irq", 16'(collide_irq), 16'h0000);
    tick();
    tick();
    frame_tick = 1'b0;
    tick();
    rd(3'd6, rv); chk("conflict_framecnt", rv, 16'h0007);
    frame("next_done", 1'b1);
    chk("next_x1", 16'(spr1_x), 16'h0021);

    // Reset in the middle of a sequence
    frame_tick = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    frame_tick = 1'b0;
    rd(3'd1, rv); chk("midrst_status", rv, 16'h0000);
    rd(3'd6, rv); chk("midrst_framecnt", rv, 16'h0000);
    chk("midrst_pos", {spr0_x, spr1_x}, 16'h0000);
    tick();
    chk("midrst_done", 16'(update_done), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
